// File: rtl/xadac_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NumReq requesters.
// The requester index rides in the upper AR ID bits and steers R beats back.
module xadac_axi_rd_arbiter #(
   parameter int unsigned NumReq         = 3,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned MaxOutstanding = 8,
   localparam int unsigned SelWidth      = $clog2(NumReq),
   localparam int unsigned MstIdWidth    = SelWidth + IdWidth,
   localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NumReq-1:0]           slv_ar_valid,
   output logic [NumReq-1:0]           slv_ar_ready,
   input  logic [NumReq*IdWidth-1:0]   slv_ar_id,
   input  logic [NumReq*AddrWidth-1:0] slv_ar_addr,
   input  logic [NumReq*8-1:0]         slv_ar_len,
   output logic [NumReq-1:0]           slv_r_valid,
   input  logic [NumReq-1:0]           slv_r_ready,
   output logic [IdWidth-1:0]          slv_r_id,
   output logic [DataWidth-1:0]        slv_r_data,
   output logic [1:0]                  slv_r_resp,
   output logic                        slv_r_last,
   output logic                        mst_ar_valid,
   input  logic                        mst_ar_ready,
   output logic [MstIdWidth-1:0]       mst_ar_id,
   output logic [AddrWidth-1:0]        mst_ar_addr,
   output logic [7:0]                  mst_ar_len,
   input  logic                        mst_r_valid,
   output logic                        mst_r_ready,
   input  logic [MstIdWidth-1:0]       mst_r_id,
   input  logic [DataWidth-1:0]        mst_r_data,
   input  logic [1:0]                  mst_r_resp,
   input  logic                        mst_r_last,
   output logic [CntWidth-1:0]         outstanding
);

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [SelWidth-1:0] rr_ptr_q, rr_ptr_d;
   logic [SelWidth-1:0] lock_idx_q, lock_idx_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic [SelWidth-1:0] win_idx, gnt_idx, r_sel;
   logic                win_found, req_any, not_full, ar_hs, r_hs, r_legal, retire;

   // First valid requester at or after rr_ptr, wrapping at NumReq
   always_comb begin
      logic [SelWidth:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = {1'b0, rr_ptr_q} + (SelWidth+1)'(k);
         if (cand >= (SelWidth+1)'(NumReq)) cand = cand - (SelWidth+1)'(NumReq);
         for (int unsigned j = 0; j < NumReq; j++) begin
            if (!win_found && (cand == (SelWidth+1)'(j)) && slv_ar_valid[j]) begin
               win_found = 1'b1;
               win_idx   = SelWidth'(j);
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      lock_idx_d   = lock_idx_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      gnt_idx      = win_idx;
      req_any      = win_found;
      slv_ar_ready = '0;
      mst_ar_id    = '0;
      mst_ar_addr  = '0;
      mst_ar_len   = '0;
      slv_r_valid  = '0;

      // A stalled grant stays pinned until its handshake completes
      if (state_q == ST_LOCK) begin
         gnt_idx = lock_idx_q;
         req_any = 1'b1;
      end
      not_full     = (cnt_q < CntWidth'(MaxOutstanding));
      mst_ar_valid = rstn & req_any & not_full;
      ar_hs        = mst_ar_valid & mst_ar_ready;

      for (int unsigned i = 0; i < NumReq; i++) begin
         if (gnt_idx == SelWidth'(i)) begin
            slv_ar_ready[i] = mst_ar_valid & mst_ar_ready;
            mst_ar_id       = {gnt_idx, slv_ar_id[i*IdWidth +: IdWidth]};
            mst_ar_addr     = slv_ar_addr[i*AddrWidth +: AddrWidth];
            mst_ar_len      = slv_ar_len[i*8 +: 8];
         end
      end

      case (state_q)
         ST_ARB: begin
            if (mst_ar_valid && !mst_ar_ready) begin
               state_d    = ST_LOCK;
               lock_idx_d = win_idx;
            end
         end
         ST_LOCK: begin
            if (ar_hs) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase

      if (ar_hs) begin
         rr_ptr_d = (gnt_idx == SelWidth'(NumReq - 1)) ? '0 : gnt_idx + SelWidth'(1);
      end

      // Unknown requester prefixes are sunk so the master never stalls on them
      r_sel       = mst_r_id[IdWidth +: SelWidth];
      r_legal     = ({1'b0, r_sel} < (SelWidth+1)'(NumReq));
      mst_r_ready = rstn & ~r_legal;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (r_sel == SelWidth'(i)) begin
            slv_r_valid[i] = rstn & mst_r_valid;
            mst_r_ready    = rstn & slv_r_ready[i];
         end
      end
      r_hs   = mst_r_valid & mst_r_ready;
      retire = r_hs & mst_r_last & (cnt_q != '0);

      case ({ar_hs, retire})
         2'b10:   cnt_d = cnt_q + CntWidth'(1);
         2'b01:   cnt_d = cnt_q - CntWidth'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_ARB;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign slv_r_id    = mst_r_id[IdWidth-1:0];
   assign slv_r_data  = mst_r_data;
   assign slv_r_resp  = mst_r_resp;
   assign slv_r_last  = mst_r_last;
   assign outstanding = cnt_q;

endmodule

// File: tb/tb_xadac_axi_rd_arbiter.sv
// Bench for xadac_axi_rd_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order and burst count.
module tb_xadac_axi_rd_arbiter;
   localparam int N  = 3;
   localparam int IW = 4;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int MO = 8;
   localparam int SW = 2;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rstn;
   logic [N-1:0]      slv_ar_valid, slv_ar_ready, slv_r_valid, slv_r_ready;
   logic [N*IW-1:0]   slv_ar_id;
   logic [N*AW-1:0]   slv_ar_addr;
   logic [N*8-1:0]    slv_ar_len;
   logic [IW-1:0]     slv_r_id;
   logic [DW-1:0]     slv_r_data, mst_r_data;
   logic [1:0]        slv_r_resp, mst_r_resp;
   logic              slv_r_last, mst_r_last;
   logic              mst_ar_valid, mst_ar_ready, mst_r_valid, mst_r_ready;
   logic [SW+IW-1:0]  mst_ar_id, mst_r_id;
   logic [AW-1:0]     mst_ar_addr;
   logic [7:0]        mst_ar_len;
   logic [CW-1:0]     outstanding;

   logic [IW-1:0] ar_id   [N];
   logic [AW-1:0] ar_addr [N];
   logic [7:0]    ar_len  [N];

   int checks = 0;
   int failures = 0;
   int m_ptr, m_cnt, m_lock;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         slv_ar_id[i*IW +: IW]   = ar_id[i];
         slv_ar_addr[i*AW +: AW] = ar_addr[i];
         slv_ar_len[i*8 +: 8]    = ar_len[i];
      end
   end

   xadac_axi_rd_arbiter #(
      .NumReq(N), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready), .slv_ar_id(slv_ar_id),
      .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len),
      .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready), .slv_r_id(slv_r_id),
      .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
      .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_ar_id(mst_ar_id),
      .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len),
      .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready), .mst_r_id(mst_r_id),
      .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
      .outstanding(outstanding)
   );

   // Reference model: grant = stalled requester if any, else first valid from m_ptr (mod N)
   function automatic int exp_grant();
      int idx;
      if (m_lock >= 0) return m_lock;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (slv_ar_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit exp_ar_valid();
      return (exp_grant() >= 0) && (m_cnt < MO);
   endfunction

   function automatic int r_target();
      return int'(mst_r_id[IW +: SW]);
   endfunction

   function automatic bit exp_mst_r_ready();
      int s = r_target();
      return (s < N) ? slv_r_ready[s] : 1'b1;
   endfunction

   task automatic model_update();
      int g = exp_grant();
      bit arv = exp_ar_valid();
      bit acc = arv && mst_ar_ready;
      bit ret = mst_r_valid && exp_mst_r_ready() && mst_r_last && (m_cnt > 0);
      if (acc) begin
         m_ptr  = (g + 1) % N;
         m_lock = -1;
      end else if (arv) begin
         m_lock = g;
      end
      m_cnt = m_cnt + int'(acc) - int'(ret);
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      slv_ar_valid = '0;
      slv_r_ready  = '0;
      mst_ar_ready = 1'b0;
      mst_r_valid  = 1'b0;
      mst_r_id     = '0;
      mst_r_data   = '0;
      mst_r_resp   = '0;
      mst_r_last   = 1'b0;
      for (int i = 0; i < N; i++) begin
         ar_id[i]   = '0;
         ar_addr[i] = '0;
         ar_len[i]  = '0;
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_cnt  = 0;
      m_lock = -1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      slv_ar_valid = 3'b111;
      mst_ar_ready = 1'b1;
      mst_r_valid  = 1'b1;
      slv_r_ready  = 3'b111;
      #1;
      checks++; if (mst_ar_valid !== 1'b0) begin failures++; $display("FAIL reset_ar_valid got=%0h exp=0", mst_ar_valid); end
      checks++; if (slv_ar_ready !== 3'b000) begin failures++; $display("FAIL reset_ar_ready got=%0h exp=0", slv_ar_ready); end
      checks++; if (slv_r_valid !== 3'b000) begin failures++; $display("FAIL reset_r_valid got=%0h exp=0", slv_r_valid); end
      checks++; if (mst_r_ready !== 1'b0) begin failures++; $display("FAIL reset_r_ready got=%0h exp=0", mst_r_ready); end
      checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      @(negedge clk);
      idle_inputs();
      rstn = 1'b1;
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      do_reset();
      slv_ar_valid = 3'b001;
      ar_id[0]     = 4'd3;
      ar_addr[0]   = 64'h1000;
      mst_ar_ready = 1'b1;
      #1;
      checks++; if (mst_ar_valid !== 1'b1) begin failures++; $display("FAIL single_ar_valid got=%0h exp=1", mst_ar_valid); end
      checks++; if (mst_ar_id !== 6'h03) begin failures++; $display("FAIL single_ar_id got=%0h exp=03", mst_ar_id); end
      checks++; if (mst_ar_addr !== 64'h1000) begin failures++; $display("FAIL single_ar_addr got=%0h exp=1000", mst_ar_addr); end
      checks++; if (slv_ar_ready !== 3'b001) begin failures++; $display("FAIL single_ar_ready got=%0b exp=001", slv_ar_ready); end
      advance();
      slv_ar_valid = '0;
      mst_ar_ready = 1'b0;
      d = {$urandom, $urandom};
      mst_r_valid = 1'b1;
      mst_r_id    = 6'h03;
      mst_r_last  = 1'b1;
      mst_r_data  = d;
      slv_r_ready = 3'b001;
      #1;
      checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL single_cnt_up got=%0d exp=1", outstanding); end
      checks++; if (slv_r_valid !== 3'b001) begin failures++; $display("FAIL single_r_valid got=%0b exp=001", slv_r_valid); end
      checks++; if (slv_r_id !== 4'd3) begin failures++; $display("FAIL single_r_id got=%0h exp=3", slv_r_id); end
      checks++; if (slv_r_data !== d) begin failures++; $display("FAIL single_r_data got=%0h exp=%0h", slv_r_data, d); end
      checks++; if (mst_r_ready !== 1'b1) begin failures++; $display("FAIL single_r_ready got=%0h exp=1", mst_r_ready); end
      advance();
      idle_inputs();
      #1;
      checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL single_cnt_down got=%0d exp=0", outstanding); end
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 0, 1};
      logic [N-1:0] oh;
      do_reset();
      slv_ar_valid = 3'b111;
      mst_ar_ready = 1'b1;
      for (int i = 0; i < N; i++) ar_id[i] = 4'($urandom);
      for (int k = 0; k < 5; k++) begin
         oh = 3'b001 << exp_seq[k];
         #1;
         checks++; if (mst_ar_id[IW +: SW] !== 2'(exp_seq[k])) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, mst_ar_id[IW +: SW], exp_seq[k]); end
         checks++; if (slv_ar_ready !== oh) begin failures++; $display("FAIL rr_ready[%0d] got=%0b exp=%0b", k, slv_ar_ready, oh); end
         advance();
      end
      idle_inputs();
      #1;
      checks++; if (outstanding !== 4'd5) begin failures++; $display("FAIL rr_cnt got=%0d exp=5", outstanding); end
   endtask

   task automatic test_lock();
      logic [AW-1:0] a;
      do_reset();
      a = {$urandom, $urandom};
      ar_id[1]     = 4'hA;
      ar_addr[1]   = a;
      ar_len[1]    = 8'd7;
      slv_ar_valid = 3'b010;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (mst_ar_valid !== 1'b1) begin failures++; $display("FAIL lock_valid[%0d] got=%0h exp=1", c, mst_ar_valid); end
         checks++; if (mst_ar_id !== 6'h1A) begin failures++; $display("FAIL lock_id[%0d] got=%0h exp=1a", c, mst_ar_id); end
         checks++; if (mst_ar_addr !== a) begin failures++; $display("FAIL lock_addr[%0d] got=%0h exp=%0h", c, mst_ar_addr, a); end
         checks++; if (mst_ar_len !== 8'd7) begin failures++; $display("FAIL lock_len[%0d] got=%0d exp=7", c, mst_ar_len); end
         checks++; if (slv_ar_ready !== 3'b000) begin failures++; $display("FAIL lock_ready[%0d] got=%0b exp=000", c, slv_ar_ready); end
         advance();
         if (c == 0) slv_ar_valid[0] = 1'b1;
      end
      mst_ar_ready    = 1'b1;
      slv_ar_valid[2] = 1'b1;
      #1;
      checks++; if (slv_ar_ready !== 3'b010) begin failures++; $display("FAIL lock_accept got=%0b exp=010", slv_ar_ready); end
      advance();
      slv_ar_valid[1] = 1'b0;
      #1;
      checks++; if (mst_ar_id[IW +: SW] !== 2'd2) begin failures++; $display("FAIL lock_next got=%0d exp=2", mst_ar_id[IW +: SW]); end
      advance();
      slv_ar_valid[2] = 1'b0;
      #1;
      checks++; if (mst_ar_id[IW +: SW] !== 2'd0) begin failures++; $display("FAIL lock_wrap got=%0d exp=0", mst_ar_id[IW +: SW]); end
      advance();
      idle_inputs();
   endtask

   task automatic test_full();
      do_reset();
      slv_ar_valid = 3'b001;
      mst_ar_ready = 1'b1;
      repeat (MO) advance();
      mst_r_valid = 1'b1;
      mst_r_id    = 6'h00;
      mst_r_last  = 1'b1;
      slv_r_ready = 3'b001;
      #1;
      checks++; if (outstanding !== 4'(MO)) begin failures++; $display("FAIL full_cnt got=%0d exp=%0d", outstanding, MO); end
      checks++; if (mst_ar_valid !== 1'b0) begin failures++; $display("FAIL full_ar_valid got=%0h exp=0", mst_ar_valid); end
      checks++; if (slv_ar_ready !== 3'b000) begin failures++; $display("FAIL full_ar_ready got=%0b exp=000", slv_ar_ready); end
      advance();
      mst_r_valid = 1'b0;
      #1;
      checks++; if (outstanding !== 4'(MO-1)) begin failures++; $display("FAIL full_retire got=%0d exp=%0d", outstanding, MO-1); end
      checks++; if (slv_ar_ready !== 3'b001) begin failures++; $display("FAIL full_reopen got=%0b exp=001", slv_ar_ready); end
      mst_r_valid = 1'b1;
      advance();
      mst_r_valid = 1'b0;
      #1;
      checks++; if (outstanding !== 4'(MO-1)) begin failures++; $display("FAIL full_same_cycle got=%0d exp=%0d", outstanding, MO-1); end
      advance();
      #1;
      checks++; if (outstanding !== 4'(MO) || mst_ar_valid !== 1'b0) begin failures++; $display("FAIL full_refill got cnt=%0d valid=%0h exp cnt=%0d valid=0", outstanding, mst_ar_valid, MO); end
      idle_inputs();
   endtask

   task automatic test_r_burst();
      logic [DW-1:0] beats [4];
      int got = 0;
      int cyc = 0;
      logic rdy;
      do_reset();
      slv_ar_valid = 3'b100;
      ar_id[2]     = 4'd5;
      mst_ar_ready = 1'b1;
      advance();
      slv_ar_valid = '0;
      mst_ar_ready = 1'b0;
      for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
      while (got < 4 && cyc < 20) begin
         rdy         = (cyc % 2 == 0);
         slv_r_ready = {rdy, 2'b11};
         mst_r_valid = 1'b1;
         mst_r_id    = 6'h25;
         mst_r_data  = beats[got];
         mst_r_resp  = 2'(got);
         mst_r_last  = (got == 3);
         #1;
         checks++; if (mst_r_ready !== rdy) begin failures++; $display("FAIL burst_ready[%0d] got=%0h exp=%0h", cyc, mst_r_ready, rdy); end
         checks++; if (slv_r_valid !== 3'b100) begin failures++; $display("FAIL burst_valid[%0d] got=%0b exp=100", cyc, slv_r_valid); end
         checks++; if (slv_r_data !== beats[got] || slv_r_id !== 4'd5) begin failures++; $display("FAIL burst_payload[%0d] got=%0h/%0h exp=%0h/5", cyc, slv_r_data, slv_r_id, beats[got]); end
         checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL burst_cnt[%0d] got=%0d exp=1", cyc, outstanding); end
         advance();
         if (rdy) got++;
         cyc++;
      end
      mst_r_valid = 1'b0;
      checks++; if (got != 4) begin failures++; $display("FAIL burst_timeout got=%0d beats exp=4", got); end
      #1;
      checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL burst_retire got=%0d exp=0", outstanding); end
      slv_ar_valid = 3'b001;
      mst_ar_ready = 1'b1;
      advance();
      slv_ar_valid = '0;
      mst_ar_ready = 1'b0;
      slv_r_ready  = 3'b000;
      mst_r_valid  = 1'b1;
      mst_r_id     = 6'h31;
      mst_r_last   = 1'b1;
      #1;
      checks++; if (slv_r_valid !== 3'b000) begin failures++; $display("FAIL illegal_valid got=%0b exp=000", slv_r_valid); end
      checks++; if (mst_r_ready !== 1'b1) begin failures++; $display("FAIL illegal_ready got=%0h exp=1", mst_r_ready); end
      advance();
      idle_inputs();
      #1;
      checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL illegal_retire got=%0d exp=0", outstanding); end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      slv_ar_valid = 3'b001;
      mst_ar_ready = 1'b1;
      repeat (5) advance();
      slv_ar_valid = 3'b010;
      mst_ar_ready = 1'b0;
      advance();
      #1;
      checks++; if (outstanding !== 4'd5 || mst_ar_id[IW +: SW] !== 2'd1) begin failures++; $display("FAIL midlock_setup got cnt=%0d gnt=%0d exp cnt=5 gnt=1", outstanding, mst_ar_id[IW +: SW]); end
      mst_ar_ready = 1'b1;
      mst_r_valid  = 1'b1;
      mst_r_id     = 6'h10;
      slv_r_ready  = 3'b111;
      rstn         = 1'b0;
      #1;
      checks++; if (mst_ar_valid !== 1'b0 || slv_ar_ready !== 3'b000) begin failures++; $display("FAIL midlock_ar got valid=%0h ready=%0b exp 0/000", mst_ar_valid, slv_ar_ready); end
      checks++; if (slv_r_valid !== 3'b000 || mst_r_ready !== 1'b0) begin failures++; $display("FAIL midlock_r got valid=%0b ready=%0h exp 000/0", slv_r_valid, mst_r_ready); end
      checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL midlock_cnt got=%0d exp=0", outstanding); end
      model_reset();
      @(negedge clk);
      idle_inputs();
      rstn         = 1'b1;
      slv_ar_valid = 3'b011;
      mst_ar_ready = 1'b1;
      #1;
      checks++; if (mst_ar_id[IW +: SW] !== 2'd0 || slv_ar_ready !== 3'b001) begin failures++; $display("FAIL midlock_first got gnt=%0d ready=%0b exp 0/001", mst_ar_id[IW +: SW], slv_ar_ready); end
      advance();
      idle_inputs();
   endtask

   task automatic test_random();
      int g;
      logic [N-1:0] e_ar_ready, e_r_valid;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_lock != i) begin
               slv_ar_valid[i] = ($urandom % 3 != 0);
               ar_id[i]        = 4'($urandom);
               ar_addr[i]      = {$urandom, $urandom};
               ar_len[i]       = 8'($urandom);
            end
         end
         mst_ar_ready = (c < 300) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
         mst_r_valid  = ($urandom % 2 == 0);
         mst_r_id     = {2'($urandom_range(0, 3)), 4'($urandom)};
         mst_r_last   = (c < 300) ? ($urandom % 3 == 0) : ($urandom % 8 != 0);
         mst_r_data   = {$urandom, $urandom};
         slv_r_ready  = 3'($urandom);
         #1;
         g = exp_grant();
         e_ar_ready = '0;
         if (exp_ar_valid() && mst_ar_ready) e_ar_ready[g] = 1'b1;
         e_r_valid = '0;
         if (mst_r_valid && r_target() < N) e_r_valid[r_target()] = 1'b1;
         checks++; if (mst_ar_valid !== exp_ar_valid()) begin failures++; $display("FAIL rnd_ar_valid[%0d] got=%0h exp=%0h", c, mst_ar_valid, exp_ar_valid()); end
         if (exp_ar_valid()) begin
            checks++; if (mst_ar_id !== {2'(g), ar_id[g]} || mst_ar_addr !== ar_addr[g] || mst_ar_len !== ar_len[g]) begin failures++; $display("FAIL rnd_ar_payload[%0d] got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, mst_ar_id, mst_ar_addr, mst_ar_len, {2'(g), ar_id[g]}, ar_addr[g], ar_len[g]); end
         end
         checks++; if (slv_ar_ready !== e_ar_ready) begin failures++; $display("FAIL rnd_ar_ready[%0d] got=%0b exp=%0b", c, slv_ar_ready, e_ar_ready); end
         checks++; if (slv_r_valid !== e_r_valid) begin failures++; $display("FAIL rnd_r_valid[%0d] got=%0b exp=%0b", c, slv_r_valid, e_r_valid); end
         checks++; if (mst_r_ready !== exp_mst_r_ready()) begin failures++; $display("FAIL rnd_r_ready[%0d] got=%0h exp=%0h", c, mst_r_ready, exp_mst_r_ready()); end
         checks++; if (slv_r_data !== mst_r_data || slv_r_id !== mst_r_id[IW-1:0]) begin failures++; $display("FAIL rnd_r_payload[%0d] got=%0h/%0h exp=%0h/%0h", c, slv_r_data, slv_r_id, mst_r_data, mst_r_id[IW-1:0]); end
         checks++; if (outstanding !== 4'(m_cnt)) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", c, outstanding, m_cnt); end
         advance();
      end
      idle_inputs();
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_full();
      test_r_burst();
      test_reset_mid_lock();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
